nco_phase_gen: RTL and testbench
================================

Name: nco_phase_gen

Overview:
- Numerically controlled oscillator phase front end; drives the two address ports of the 1024x18 dual-port sine ROM.
- Port A address addresses sine; port B address is offset by a quarter turn and addresses cosine.
- Generates a data-valid strobe that is delay-matched to the ROM's 2-cycle read latency (BRAM plus output register), so downstream mixers can qualify da/db.

Parameters:
- ACC_W, 32, phase accumulator width.
- ADDR_W, 10, ROM address width; the top ADDR_W accumulator bits form the address.
- QUAD_OFFSET, 256, port-B address offset (quarter of 2^ADDR_W).
- ROM_LAT, 2, ROM read latency in clocks used to align dv.

Ports:
- clk  in  1  single clock, shared with the ROM.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  enable; while 1 the accumulator advances.
- freq  in  ACC_W  frequency tuning word (unsigned).
- freq_ld  in  1  one-cycle strobe that captures freq.
- phase_ofs  in  ADDR_W  static phase offset added after truncation.
- ofs_ld  in  1  one-cycle strobe that captures phase_ofs.
- sync  in  1  one-cycle strobe that zeroes the accumulator.
- aa  out  ADDR_W  ROM port A address (sine).
- ab  out  ADDR_W  ROM port B address (cosine).
- av  out  1  aa/ab valid this cycle.
- dv  out  1  ROM outputs da/db valid this cycle; av delayed ROM_LAT clocks.

Behaviour:
- Reset (rst=0, asynchronous):
  - acc, finc and ofs are 0.
  - aa, ab, av and dv are 0.
  - Delay pipe is cleared and state is IDLE.
  - Deassertion takes effect at the next clk edge.
- Registers:
  - finc is loaded from freq on the edge where freq_ld=1.
  - ofs is loaded from phase_ofs on the edge where ofs_ld=1.
  - Both load regardless of state, and the new value is used from the following edge.
- State machine (IDLE, RUN, DRAIN):
  - IDLE: run=1 goes to RUN; otherwise stays in IDLE.
  - RUN: run=0 goes to DRAIN with a counter loaded with ROM_LAT.
  - DRAIN: counter decrements each cycle; at 0 goes to IDLE; run=1 returns to RUN immediately.
- Advance (every edge in RUN with run=1):
  - aa <= acc[ACC_W-1 -: ADDR_W] + ofs, modulo 2^ADDR_W.
  - ab <= aa_next + QUAD_OFFSET, modulo 2^ADDR_W.
  - acc <= acc + finc, modulo 2^ACC_W; the carry is dropped (wrap-around).
  - av <= 1.
  - Net effect: the address emitted reflects acc before its increment.
- Non-advancing cycles (IDLE, DRAIN, or run=0):
  - acc, aa and ab hold their values.
  - av <= 0.
- sync:
  - Next-edge value of acc is 0, overriding the increment.
  - If advancing on the same edge, aa/ab still use the pre-sync acc.
  - The address from the following advance is 0+ofs.
  - sync with freq_ld on the same edge: both take effect.
- dv:
  - dv is av delayed through a ROM_LAT-stage shift register.
  - The delay pipe keeps shifting in all states, so the DRAIN state flushes it.
  - dv=1 marks cycles where da/db correspond to an emitted address.
- finc=0: addresses stay constant while av=1.
- rst asserted mid-run: all outputs go to 0 immediately, including dv; no partial drain.

Optional Feature:
- Macro: NCO_DITHER_EN.
- Enabled:
  - 15-bit Fibonacci LFSR (x^15+x^14+1), seed 1 at reset, steps on every advance.
  - Its low min(15, ACC_W-ADDR_W) bits, zero-extended, are added to acc before truncation for the aa/ab computation only.
  - The dither is never accumulated into acc.
  - Spreads the phase-truncation spurs.
- Disabled: plain truncation; no LFSR logic is present.

Test Plan (all with NCO_DITHER_EN off):
- Reset/idle: hold rst=0 for 3 clocks, release with run=0 -> aa=ab=0, av=dv=0 for 10 clocks.
- Sequence:
  - Stimulus: freq=32'h0040_0000 with freq_ld, then run=1.
  - aa: 0,1,2,3,... on successive av cycles.
  - ab: 256,257,...
  - Timing: av rises 1 clock after the first RUN edge; dv rises ROM_LAT=2 clocks after av.
- Wrap:
  - Stimulus: freq=32'h4000_0000.
  - aa: 0,256,512,768,0,...
  - ab: 256,512,768,0,...
- Offset and sync:
  - Stimulus: phase_ofs=10'd1020 with ofs_ld, freq=32'h0040_0000; after 5 advances pulse sync.
  - Required: aa wraps 1023->0->1; the address after the sync edge is 1020.
- Drain:
  - Stimulus: drop run after 8 advances.
  - Required: av=0 next cycle; dv stays 1 for 2 more cycles then 0; state returns to IDLE; aa held.
  - Reassert run during DRAIN -> av=1 on the next edge and addresses continue.
- Mid-run reset: pulse rst low for 1 clock while running -> aa, ab, av, dv go to 0 asynchronously; after release with run=1, aa restarts at 0.

Source files
------------

// File: rtl/nco_phase_gen.sv
// nco_phase_gen: NCO phase front end driving both address ports of a
// 1024x18 dual-port sine ROM. Port A addresses sine and port B, a quarter
// turn ahead, addresses cosine. dv is av delayed to line up with the ROM's
// registered read data.
// Optional feature macro: NCO_DITHER_EN adds LFSR phase dither ahead of
// address truncation. The dither never enters the accumulator.
module nco_phase_gen #(
  parameter int ACC_W       = 32,
  parameter int ADDR_W      = 10,
  parameter int QUAD_OFFSET = 256,
  parameter int ROM_LAT     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,       // active-low, asynchronous
  input  logic              run_i,
  input  logic [ACC_W-1:0]  freq_i,
  input  logic              freq_ld_i,
  input  logic [ADDR_W-1:0] phase_ofs_i,
  input  logic              ofs_ld_i,
  input  logic              sync_i,
  output logic [ADDR_W-1:0] aa_o,
  output logic [ADDR_W-1:0] ab_o,
  output logic              av_o,
  output logic              dv_o
);

  localparam int CNT_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               adv;

  logic [ACC_W-1:0]   acc_q, acc_d, acc_tap;
  logic [ACC_W-1:0]   finc_q;
  logic [ADDR_W-1:0]  ofs_q;
  logic [ADDR_W-1:0]  aa_q, ab_q, aa_d, ab_d;
  logic               av_q;
  logic [ROM_LAT-1:0] vld_pipe_q;

  // State register and drain counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The accumulator advances only in RUN with run held high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
    case (state_q)
      IDLE:  if (run_i) state_d = RUN;
      RUN: begin
        if (run_i) begin
          adv = 1'b1;
        end else begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(ROM_LAT);
        end
      end
      DRAIN: begin
        if (run_i)             state_d = RUN;
        else if (cnt_q == '0)  state_d = IDLE;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef NCO_DITHER_EN
  localparam int DW = ((ACC_W - ADDR_W) < 15) ? (ACC_W - ADDR_W) : 15;
  logic [14:0] lfsr_q;

  // x^15 + x^14 + 1 Fibonacci LFSR. It steps only when an address is emitted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)   lfsr_q <= 15'd1;
    else if (adv) lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
  end

  // The dither only perturbs the value being truncated.
  assign acc_tap = acc_q + {{(ACC_W-DW){1'b0}}, lfsr_q[DW-1:0]};
`else
  assign acc_tap = acc_q;
`endif

  // Addresses come from the accumulator value before this edge's increment.
  // sync overrides the increment but does not affect the address emitted now.
  always_comb begin
    aa_d  = acc_tap[ACC_W-1 -: ADDR_W] + ofs_q;
    ab_d  = aa_d + ADDR_W'(QUAD_OFFSET);
    acc_d = acc_q;
    if (sync_i)   acc_d = '0;
    else if (adv) acc_d = acc_q + finc_q;
  end

  // Tuning registers, accumulator and address outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      finc_q <= '0;
      ofs_q  <= '0;
      acc_q  <= '0;
      aa_q   <= '0;
      ab_q   <= '0;
      av_q   <= 1'b0;
    end else begin
      if (freq_ld_i) finc_q <= freq_i;
      if (ofs_ld_i)  ofs_q  <= phase_ofs_i;
      acc_q <= acc_d;
      av_q  <= adv;
      if (adv) begin
        aa_q <= aa_d;
        ab_q <= ab_d;
      end
    end
  end

  // The valid delay line shifts in every state, so DRAIN flushes it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= av_q;
      for (int i = 1; i < ROM_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign aa_o = aa_q;
  assign ab_o = ab_q;
  assign av_o = av_q;
  assign dv_o = vld_pipe_q[ROM_LAT-1];

endmodule

// File: tb/tb_nco_phase_gen.sv
// tb_nco_phase_gen: directed scenario tasks with constant expectations, plus
// a randomized run compared against a cycle-level behavioural model.
module tb_nco_phase_gen;

  logic        clk, rst, run, freq_ld, ofs_ld, sync;
  logic [31:0] freq;
  logic [9:0]  phase_ofs;
  logic [9:0]  aa, ab;
  logic        av, dv;

  int total = 0;
  int bad   = 0;

  nco_phase_gen dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .freq_i(freq), .freq_ld_i(freq_ld),
    .phase_ofs_i(phase_ofs), .ofs_ld_i(ofs_ld), .sync_i(sync),
    .aa_o(aa), .ab_o(ab), .av_o(av), .dv_o(dv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. The block is in RUN after any edge that sampled
  // run=1, so an edge advances exactly when run was 1 on it and on the edge
  // before. dv repeats av from ROM_LAT (=2) edges earlier.
  bit [31:0] m_acc, m_finc;
  bit [9:0]  m_ofs, m_aa, m_ab;
  bit        m_av, m_dv, m_prev_run;
  bit        mq[$];

  function automatic void model_reset();
    m_acc = 0; m_finc = 0; m_ofs = 0; m_aa = 0; m_ab = 0;
    m_av = 0; m_dv = 0; m_prev_run = 0;
    mq.delete();
    mq.push_back(1'b0);
    mq.push_back(1'b0);
  endfunction

  function automatic void model_edge();
    bit adv;
    int unsigned t;
    if (!rst) begin
      model_reset();
      return;
    end
    adv = m_prev_run && run;
    if (adv) begin
      t    = (m_acc / 32'd4194304) + m_ofs;  // acc / 2^22 is the top 10 bits
      m_aa = 10'(t % 1024);
      m_ab = 10'((t + 256) % 1024);
    end
    m_dv = mq.pop_front();
    mq.push_back(adv);
    m_av = adv;
    if (sync)     m_acc = 0;
    else if (adv) m_acc = m_acc + m_finc;
    if (freq_ld) m_finc = freq;
    if (ofs_ld)  m_ofs  = phase_ofs;
    m_prev_run = run;
  endfunction

  // One clock. The model sees the same inputs as the DUT edge, and outputs
  // are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; freq_ld = 1'b0; ofs_ld = 1'b0; sync = 1'b0;
    model_reset();
    repeat (3) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    repeat (3) step();
    if ({aa, ab, av, dv} !== 22'd0) begin
      bad++; $display("FAIL reset_in: got aa=%0d ab=%0d av=%b dv=%b want all 0", aa, ab, av, dv);
    end
    total++;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({aa, ab, av, dv} !== 22'd0) begin
        bad++; $display("FAIL idle[%0d]: got aa=%0d ab=%0d av=%b dv=%b want all 0", i, aa, ab, av, dv);
      end
      total++;
    end
  endtask

  task automatic test_sequence();
    do_reset();
    freq = 32'h0040_0000; freq_ld = 1'b1;
    step();
    freq_ld = 1'b0; run = 1'b1;
    step();  // IDLE->RUN edge, nothing emitted yet
    if (av !== 1'b0) begin bad++; $display("FAIL seq_av_pre: got %b want 0", av); end
    total++;
    for (int i = 0; i < 8; i++) begin
      step();
      if (aa !== 10'(i)) begin bad++; $display("FAIL seq_aa[%0d]: got %0d want %0d", i, aa, i); end
      if (ab !== 10'(i + 256)) begin bad++; $display("FAIL seq_ab[%0d]: got %0d want %0d", i, ab, i + 256); end
      if (av !== 1'b1) begin bad++; $display("FAIL seq_av[%0d]: got %b want 1", i, av); end
      if (dv !== (i >= 2)) begin bad++; $display("FAIL seq_dv[%0d]: got %b want %b", i, dv, (i >= 2)); end
      total += 4;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    freq = 32'h4000_0000; freq_ld = 1'b1; run = 1'b1;
    step();
    freq_ld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (aa !== 10'((i * 256) % 1024)) begin
        bad++; $display("FAIL wrap_aa[%0d]: got %0d want %0d", i, aa, (i * 256) % 1024);
      end
      if (ab !== 10'((i * 256 + 256) % 1024)) begin
        bad++; $display("FAIL wrap_ab[%0d]: got %0d want %0d", i, ab, (i * 256 + 256) % 1024);
      end
      total += 2;
    end
  endtask

  task automatic test_ofs_sync();
    do_reset();
    freq = 32'h0040_0000; freq_ld = 1'b1;
    phase_ofs = 10'd1020; ofs_ld = 1'b1; run = 1'b1;
    step();
    freq_ld = 1'b0; ofs_ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (aa !== 10'((1020 + i) % 1024)) begin
        bad++; $display("FAIL ofs_aa[%0d]: got %0d want %0d", i, aa, (1020 + i) % 1024);
      end
      total++;
    end
    sync = 1'b1;
    step();  // this address still uses the pre-sync accumulator
    sync = 1'b0;
    if (aa !== 10'd1) begin bad++; $display("FAIL sync_same_edge: got %0d want 1", aa); end
    total++;
    step();
    if (aa !== 10'd1020) begin bad++; $display("FAIL sync_after_aa: got %0d want 1020", aa); end
    if (ab !== 10'd252) begin bad++; $display("FAIL sync_after_ab: got %0d want 252", ab); end
    total += 2;
    step();
    if (aa !== 10'd1021) begin bad++; $display("FAIL sync_next_aa: got %0d want 1021", aa); end
    total++;
  endtask

  task automatic test_drain();
    do_reset();
    freq = 32'h0040_0000; freq_ld = 1'b1; run = 1'b1;
    step();
    freq_ld = 1'b0;
    repeat (8) step();
    if (aa !== 10'd7) begin bad++; $display("FAIL drain_pre_aa: got %0d want 7", aa); end
    total++;
    run = 1'b0;
    // av drops at once, and dv covers the two reads still in flight.
    for (int i = 0; i < 5; i++) begin
      step();
      if (av !== 1'b0) begin bad++; $display("FAIL drain_av[%0d]: got %b want 0", i, av); end
      if (dv !== (i < 2)) begin bad++; $display("FAIL drain_dv[%0d]: got %b want %b", i, dv, (i < 2)); end
      if (aa !== 10'd7) begin bad++; $display("FAIL drain_aa[%0d]: got %0d want 7", i, aa); end
      total += 3;
    end
    run = 1'b1;
    step();  // back to RUN
    step();
    if (av !== 1'b1 || aa !== 10'd8) begin
      bad++; $display("FAIL resume_idle: got av=%b aa=%0d want av=1 aa=8", av, aa);
    end
    total++;
    repeat (2) step();  // aa 9, 10
    run = 1'b0;
    step();  // RUN->DRAIN
    run = 1'b1;
    step();  // DRAIN->RUN without finishing the drain
    if (av !== 1'b0 || dv !== 1'b1) begin
      bad++; $display("FAIL redrain_mid: got av=%b dv=%b want av=0 dv=1", av, dv);
    end
    total++;
    step();
    if (av !== 1'b1 || aa !== 10'd11 || ab !== 10'd267 - 10'd0) begin
      bad++; $display("FAIL redrain_resume: got av=%b aa=%0d ab=%0d want av=1 aa=11 ab=267", av, aa, ab);
    end
    total++;
  endtask

  task automatic test_midrun_reset();
    do_reset();
    freq = 32'h0040_0000; freq_ld = 1'b1;
    phase_ofs = 10'd5; ofs_ld = 1'b1; run = 1'b1;
    step();
    freq_ld = 1'b0; ofs_ld = 1'b0;
    repeat (6) step();
    if (aa !== 10'd10 || av !== 1'b1) begin
      bad++; $display("FAIL mrst_pre: got aa=%0d av=%b want aa=10 av=1", aa, av);
    end
    total++;
    #2 rst = 1'b0;
    #1;
    if ({aa, ab, av, dv} !== 22'd0) begin
      bad++; $display("FAIL mrst_async: got aa=%0d ab=%0d av=%b dv=%b want all 0", aa, ab, av, dv);
    end
    total++;
    model_reset();
    step();
    rst = 1'b1;
    step();  // IDLE->RUN
    if (av !== 1'b0 || dv !== 1'b0) begin
      bad++; $display("FAIL mrst_idle: got av=%b dv=%b want 0 0", av, dv);
    end
    total++;
    step();
    if (aa !== 10'd0 || ab !== 10'd256 || av !== 1'b1) begin
      bad++; $display("FAIL mrst_restart: got aa=%0d ab=%0d av=%b want 0 256 1", aa, ab, av);
    end
    total++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      run       = ($urandom_range(0, 9) < 8);
      freq_ld   = ($urandom_range(0, 15) == 0);
      freq      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      ofs_ld    = ($urandom_range(0, 15) == 0);
      phase_ofs = 10'($urandom());
      sync      = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) != 0);
      step();
      if (aa !== m_aa) begin bad++; $display("FAIL rnd_aa cyc %0d: got %0d want %0d", n, aa, m_aa); end
      if (ab !== m_ab) begin bad++; $display("FAIL rnd_ab cyc %0d: got %0d want %0d", n, ab, m_ab); end
      if (av !== m_av) begin bad++; $display("FAIL rnd_av cyc %0d: got %b want %b", n, av, m_av); end
      if (dv !== m_dv) begin bad++; $display("FAIL rnd_dv cyc %0d: got %b want %b", n, dv, m_dv); end
      total += 4;
    end
    rst = 1'b1; sync = 1'b0; freq_ld = 1'b0; ofs_ld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; freq = '0; freq_ld = 1'b0;
    phase_ofs = '0; ofs_ld = 1'b0; sync = 1'b0;
    model_reset();
    test_reset();
    test_sequence();
    test_wrap();
    test_ofs_sync();
    test_drain();
    test_midrun_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
